aidc_lite_decomp_ctrl: RTL and testbench

Front-end controller for the AIDC-Lite decompression path. It accepts one compressed 512-bit line per packet on a 32-bit stream and decodes the 2-bit prefix in the first word. It then steers the packet to the selected decompression engine, or handles raw lines itself. It merges the engines' OR-shared write ports into an 8x64 line buffer and releases the finished line on a valid/ready output. It sits between the compressed-data fetch path and the line consumer.

---
 rtl/aidc_lite_pkg.sv | 25 ++
 rtl/aidc_lite_line_buf.sv | 33 +++
 rtl/aidc_lite_decomp_ctrl.sv | 173 +++++++++++++++++
 tb/tb_aidc_lite_decomp_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_pkg.sv
// Shared types and constants for the AIDC-Lite decompression front end.
package aidc_lite_pkg;

    localparam logic [1:0] PFX_RAW  = 2'b00;
    localparam logic [1:0] PFX_ZRLE = 2'b01;
    localparam logic [1:0] PFX_LZ   = 2'b10;

    localparam int LINE_ENTRIES  = 8;
    localparam int ENTRY_W       = 64;
    localparam int IDX_W         = 3;
    localparam int ADDR_W        = 4;
    localparam int RAW_MAX_BEATS = 2 * LINE_ENTRIES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DRAIN,
        ST_OUT
    } state_e;

    function automatic logic pfx_is_eng(input logic [1:0] pfx, input int num_eng);
        return (pfx != PFX_RAW) && (int'(pfx) <= num_eng);
    endfunction

endpackage

// File: rtl/aidc_lite_line_buf.sv
// 8x64 line buffer with a fill bitmap; clear wins over a same-cycle write.
module aidc_lite_line_buf
    import aidc_lite_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [ENTRY_W-1:0]              wr_data,
    output logic [LINE_ENTRIES*ENTRY_W-1:0] line,
    output logic                            full,
    output logic                            dup
);

    logic [LINE_ENTRIES-1:0][ENTRY_W-1:0] mem_q;
    logic [LINE_ENTRIES-1:0]              bitmap_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            mem_q    <= '0;
            bitmap_q <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx]    <= wr_data;
            bitmap_q[wr_idx] <= 1'b1;
        end
    end

    assign line = mem_q;
    assign full = &bitmap_q;
    assign dup  = wr_en & bitmap_q[wr_idx];

endmodule

// File: rtl/aidc_lite_decomp_ctrl.sv
// AIDC-Lite front end: prefix decode, engine steering, raw-line packing,
// engine write merge into the line buffer and line release.
//
// state | meaning
// IDLE  | waiting for SOP of a new packet
// RECV  | packet beats being accepted and steered
// DRAIN | EOP seen, waiting for the line to fill or time out
// OUT   | line presented, held until out_ready_i
module aidc_lite_decomp_ctrl
    import aidc_lite_pkg::*;
#(
    parameter int NUM_ENG       = 2,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic                            in_sop_i,
    input  logic                            in_eop_i,
    input  logic [31:0]                     in_data_i,
    output logic [NUM_ENG-1:0]              eng_valid_o,
    output logic                            eng_sop_o,
    output logic                            eng_eop_o,
    output logic [31:0]                     eng_data_o,
    input  logic [NUM_ENG-1:0]              eng_wr_valid_i,
    input  logic [ADDR_W*NUM_ENG-1:0]       eng_wr_addr_i,
    input  logic [ENTRY_W*NUM_ENG-1:0]      eng_wr_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [LINE_ENTRIES*ENTRY_W-1:0] out_data_o,
    output logic                            out_err_o,
    output logic                            proto_err_o
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [1:0]         pfx_q, pfx_cur;
    logic               err_q, err_d;
    logic [4:0]         raw_cnt_q;
    logic [31:0]        raw_hi_q;
    logic [CNT_W-1:0]   drain_cnt_q;
    logic               proto_d;
    logic [NUM_ENG-1:0] eng_valid_d;

    logic beat, start, payload, drop, cur_eng, fwd;
    logic raw_beat, raw_over, raw_wr;
    logic wr_window, eng_wr_any, eng_wr_multi, eng_wr_ok, eng_addr_bad;
    logic drain_tc, timeout;

    logic [ADDR_W-1:0]              wr_addr_or;
    logic [ENTRY_W-1:0]             wr_data_or;
    logic                           lb_wr_en, lb_full, lb_dup;
    logic [IDX_W-1:0]               lb_idx;
    logic [ENTRY_W-1:0]             lb_data;
    logic [LINE_ENTRIES*ENTRY_W-1:0] lb_line;

    assign in_ready_o = (state_q == ST_IDLE) || (state_q == ST_RECV);
    assign beat       = in_valid_i & in_ready_o;
    assign start      = beat & in_sop_i;
    assign payload    = beat & ~in_sop_i & (state_q == ST_RECV);
    assign drop       = beat & ~in_sop_i & (state_q == ST_IDLE);
    assign pfx_cur    = start ? in_data_i[31:30] : pfx_q;
    assign cur_eng    = pfx_is_eng(pfx_cur, NUM_ENG);
    assign fwd        = (start | payload) & cur_eng;

    // Raw payload: even beat is held as the upper half, odd beat completes the entry.
    assign raw_beat = payload & (pfx_q == PFX_RAW);
    assign raw_over = raw_beat & (raw_cnt_q >= 5'(RAW_MAX_BEATS));
    assign raw_wr   = raw_beat & raw_cnt_q[0] & ~raw_over;

    always_comb begin
        wr_addr_or = '0;
        wr_data_or = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            wr_addr_or = wr_addr_or | eng_wr_addr_i[ADDR_W*i +: ADDR_W];
            wr_data_or = wr_data_or | eng_wr_data_i[ENTRY_W*i +: ENTRY_W];
        end
    end

    // Writes racing a restart SOP belong to the abandoned packet and are dropped.
    assign wr_window    = (state_q == ST_RECV) || (state_q == ST_DRAIN);
    assign eng_wr_any   = |eng_wr_valid_i;
    assign eng_wr_multi = $countones(eng_wr_valid_i) > 1;
    assign eng_wr_ok    = eng_wr_any & wr_window & ~start;
    assign eng_addr_bad = wr_addr_or >= ADDR_W'(LINE_ENTRIES);

    assign lb_wr_en = raw_wr | (eng_wr_ok & ~eng_addr_bad);
    assign lb_idx   = raw_wr ? raw_cnt_q[IDX_W:1] : wr_addr_or[IDX_W-1:0];
    assign lb_data  = raw_wr ? {raw_hi_q, in_data_i} : wr_data_or;

    assign drain_tc = drain_cnt_q == CNT_W'(DRAIN_TIMEOUT);
    assign timeout  = (state_q == ST_DRAIN) & ~(lb_full | err_q) & drain_tc;

    always_comb begin
        err_d = err_q;
        if (start) begin
            err_d = ~cur_eng & (pfx_cur != PFX_RAW);
        end else if (raw_over | lb_dup | timeout |
                     (eng_wr_ok & (eng_addr_bad | eng_wr_multi | raw_wr))) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        proto_d = drop | (start & (state_q == ST_RECV)) |
                  (eng_wr_any & ((state_q == ST_IDLE) || (state_q == ST_OUT)));
        for (int i = 0; i < NUM_ENG; i++) begin
            eng_valid_d[i] = fwd && (pfx_cur == 2'(i + 1));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = in_eop_i ? ST_DRAIN : ST_RECV;
            ST_RECV:  if (beat && in_eop_i) state_d = ST_DRAIN;
            ST_DRAIN: if (lb_full || err_q || drain_tc) state_d = ST_OUT;
            ST_OUT:   if (out_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pfx_q       <= PFX_RAW;
            err_q       <= 1'b0;
            raw_cnt_q   <= '0;
            raw_hi_q    <= '0;
            drain_cnt_q <= '0;
            proto_err_o <= 1'b0;
            eng_valid_o <= '0;
            eng_sop_o   <= 1'b0;
            eng_eop_o   <= 1'b0;
            eng_data_o  <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            proto_err_o <= proto_d;
            if (start) begin
                pfx_q     <= pfx_cur;
                raw_cnt_q <= '0;
            end else if (raw_beat && raw_cnt_q <= 5'(RAW_MAX_BEATS)) begin
                raw_cnt_q <= raw_cnt_q + 5'd1;
            end
            if (raw_beat && !raw_cnt_q[0]) raw_hi_q <= in_data_i;
            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + CNT_W'(1) : '0;
            eng_valid_o <= eng_valid_d;
            eng_sop_o   <= fwd & in_sop_i;
            eng_eop_o   <= fwd & in_eop_i;
            eng_data_o  <= fwd ? in_data_i : '0;
        end
    end

    aidc_lite_line_buf u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .wr_en   (lb_wr_en),
        .wr_idx  (lb_idx),
        .wr_data (lb_data),
        .line    (lb_line),
        .full    (lb_full),
        .dup     (lb_dup)
    );

    assign out_valid_o = state_q == ST_OUT;
    assign out_err_o   = out_valid_o & err_q;
    assign out_data_o  = (out_valid_o && !err_q) ? lb_line : '0;

endmodule

// File: tb/tb_aidc_lite_decomp_ctrl.sv
// Bench for aidc_lite_decomp_ctrl: packet table plus a mock engine and an
// expected-line queue, followed by restart and backpressure/reset sequences.
module tb_aidc_lite_decomp_ctrl;

    localparam int NUM_ENG       = 2;
    localparam int DRAIN_TIMEOUT = 32;
    localparam int TMO_LAT       = DRAIN_TIMEOUT + 1;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid_i, in_sop_i, in_eop_i;
    logic                     in_ready_o;
    logic [31:0]              in_data_i;
    logic [NUM_ENG-1:0]       eng_valid_o;
    logic                     eng_sop_o, eng_eop_o;
    logic [31:0]              eng_data_o;
    logic [NUM_ENG-1:0]       eng_wr_valid_i;
    logic [4*NUM_ENG-1:0]     eng_wr_addr_i;
    logic [64*NUM_ENG-1:0]    eng_wr_data_i;
    logic                     out_valid_o, out_ready_i, out_err_o, proto_err_o;
    logic [511:0]             out_data_o;

    aidc_lite_decomp_ctrl #(.NUM_ENG(NUM_ENG), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_sop_i       (in_sop_i),
        .in_eop_i       (in_eop_i),
        .in_data_i      (in_data_i),
        .eng_valid_o    (eng_valid_o),
        .eng_sop_o      (eng_sop_o),
        .eng_eop_o      (eng_eop_o),
        .eng_data_o     (eng_data_o),
        .eng_wr_valid_i (eng_wr_valid_i),
        .eng_wr_addr_i  (eng_wr_addr_i),
        .eng_wr_data_i  (eng_wr_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_err_o      (out_err_o),
        .proto_err_o    (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pfx;
        int          npay;
        logic [31:0] seed;
        int          nwr;
        logic [3:0]  extra;
        logic        exp_err;
        int          exp_beats;
        logic [1:0]  exp_mask;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic         err;
        logic [511:0] data;
    } line_t;

    vec_t  vecs[9];
    line_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    eng_beats, proto_cnt;
    logic [1:0] eng_mask;

    int          mock_nwr = 0;
    logic [3:0]  mock_extra = 4'h0;
    int          wr_left = 0, wr_i = 0, wr_eng = 0;
    logic [31:0] mock_w = '0;
    logic [3:0]  mock_a;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_data(input vec_t v);
        logic [511:0] m;
        logic [31:0]  w;
        m = '0;
        if (v.exp_err) return m;
        w = v.seed + 32'(v.npay - 1);
        for (int k = 0; k < 8; k++) begin
            if (v.pfx == 2'b00) m[64*k +: 64] = {32'(2*k), 32'(2*k + 1)};
            else                m[64*k +: 64] = {w, w};
        end
        return m;
    endfunction

    // Output monitor, sampled just after the active edge.
    initial begin
        eng_beats = 0; proto_cnt = 0; eng_mask = '0;
        forever begin
            @(posedge clk); #1;
            eng_beats += $countones(eng_valid_o);
            eng_mask  |= eng_valid_o;
            if (proto_err_o) proto_cnt++;
        end
    end

    // Mock engine: after EOP writes entries 0..7 (then mock_extra) with {w,w}.
    initial begin
        eng_wr_valid_i = '0; eng_wr_addr_i = '0; eng_wr_data_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) wr_left = 0;
            if (|eng_valid_o) begin
                wr_eng = eng_valid_o[1] ? 1 : 0;
                mock_w = eng_sop_o ? 32'h0 : eng_data_o;
                if (eng_eop_o) begin
                    wr_left = mock_nwr;
                    wr_i    = 0;
                end
            end
            eng_wr_valid_i = '0; eng_wr_addr_i = '0; eng_wr_data_i = '0;
            if (wr_left > 0) begin
                mock_a = (wr_i < 8) ? 4'(wr_i) : mock_extra;
                eng_wr_valid_i[wr_eng]         = 1'b1;
                eng_wr_addr_i[4*wr_eng +: 4]   = mock_a;
                eng_wr_data_i[64*wr_eng +: 64] = {mock_w, mock_w};
                wr_i++;
                wr_left--;
            end
        end
    end

    task automatic beat(input logic sop, input logic eop, input logic [31:0] d);
        in_valid_i = 1'b1; in_sop_i = sop; in_eop_i = eop; in_data_i = d;
        @(negedge clk);
        in_valid_i = 1'b0; in_sop_i = 1'b0; in_eop_i = 1'b0; in_data_i = '0;
    endtask

    task automatic send_packet(input vec_t v);
        beat(1'b1, v.npay == 0, {v.pfx, 30'h0});
        for (int j = 0; j < v.npay; j++)
            beat(1'b0, j == v.npay - 1, (v.pfx == 2'b00) ? 32'(j) : v.seed + 32'(j));
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, out_valid_o, 1);
    endtask

    task automatic compare_line(input string tag);
        line_t e;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s_queue: got empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, out_data_o, e.data);
            check({tag, "_err"}, out_err_o, e.err);
        end
    endtask

    task automatic handshake(input string tag);
        compare_line(tag);
        check({tag, "_ready_in_out"}, in_ready_o, 0);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        check({tag, "_idle_valid"}, out_valid_o, 0);
        check({tag, "_idle_ready"}, in_ready_o, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        line_t e;
        int    lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        eng_beats = 0; eng_mask = '0; proto_cnt = 0;
        mock_nwr = v.nwr; mock_extra = v.extra;
        e.err = v.exp_err; e.data = model_data(v);
        exp_q.push_back(e);
        send_packet(v);
        wait_out(tag, lat);
        if (v.exp_lat != 0) check({tag, "_latency"}, lat, v.exp_lat);
        handshake(tag);
        check({tag, "_eng_beats"}, eng_beats, v.exp_beats);
        check({tag, "_eng_mask"}, eng_mask, v.exp_mask);
        check({tag, "_proto"}, proto_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t  v;
        line_t e;
        int    lat;

        //          pfx    npay seed           nwr extra err  beats mask   lat
        vecs[0] = '{2'b01, 1,   32'h0,         8,  4'h0, 1'b0, 2,   2'b01, 0};
        vecs[1] = '{2'b00, 16,  32'h0,         0,  4'h0, 1'b0, 0,   2'b00, 0};
        vecs[2] = '{2'b11, 2,   32'h55,        0,  4'h0, 1'b1, 0,   2'b00, 0};
        vecs[3] = '{2'b10, 3,   32'hA5A5_0000, 8,  4'h0, 1'b0, 4,   2'b10, 0};
        vecs[4] = '{2'b01, 2,   32'h1111_0000, 7,  4'h0, 1'b1, 3,   2'b01, TMO_LAT};
        vecs[5] = '{2'b00, 10,  32'h0,         0,  4'h0, 1'b1, 0,   2'b00, TMO_LAT};
        vecs[6] = '{2'b00, 18,  32'h0,         0,  4'h0, 1'b1, 0,   2'b00, 0};
        vecs[7] = '{2'b01, 1,   32'h0BAD_F00D, 9,  4'h3, 1'b1, 2,   2'b01, 0};
        vecs[8] = '{2'b10, 1,   32'h0000_7777, 9,  4'h9, 1'b1, 2,   2'b10, 0};

        rst_n = 1'b0; in_valid_i = 1'b0; in_sop_i = 1'b0; in_eop_i = 1'b0;
        in_data_i = '0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_out_valid", out_valid_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_eng_valid", eng_valid_o, 0);
        check("rst_out_err", out_err_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_proto", proto_err_o, 0);

        // Non-SOP beat in IDLE is dropped with a protocol error.
        eng_beats = 0; proto_cnt = 0;
        beat(1'b0, 1'b0, 32'h1234_0000);
        repeat (2) @(negedge clk);
        check("drop_proto", proto_cnt, 1);
        check("drop_no_out", out_valid_o, 0);
        check("drop_no_eng", eng_beats, 0);
        check("drop_ready", in_ready_o, 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Raw packet abandoned by a new engine SOP; stale raw entry must not linger.
        eng_beats = 0; eng_mask = '0; proto_cnt = 0; mock_nwr = 8;
        v = '{2'b01, 1, 32'h1234_5678, 8, 4'h0, 1'b0, 2, 2'b01, 0};
        e.err = 1'b0; e.data = model_data(v);
        exp_q.push_back(e);
        beat(1'b1, 1'b0, {2'b00, 30'h0});
        beat(1'b0, 1'b0, 32'hDEAD_0000);
        beat(1'b0, 1'b0, 32'hDEAD_0001);
        send_packet(v);
        wait_out("restart", lat);
        handshake("restart");
        check("restart_proto", proto_cnt, 1);
        check("restart_eng_beats", eng_beats, 2);

        // Backpressure then reset while the line is presented.
        v = '{2'b10, 1, 32'hC0FF_EE00, 8, 4'h0, 1'b0, 2, 2'b10, 0};
        mock_nwr = 8;
        e.err = 1'b0; e.data = model_data(v);
        exp_q.push_back(e);
        send_packet(v);
        wait_out("bp", lat);
        compare_line("bp");
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_hold%0d_data", c), out_data_o, e.data);
            check($sformatf("bp_hold%0d_ready", c), in_ready_o, 0);
            @(negedge clk);
        end
        check("bp_still_valid", out_valid_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("bp_rst_valid", out_valid_o, 0);
        check("bp_rst_ready", in_ready_o, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("end_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
